ripple_count_sampler: RTL and testbench

RIPPLE_COUNT_SAMPLER -- requirements
Module: ripple_count_sampler

---
 rtl/ripple_sampler_pkg.sv | 23 ++
 rtl/bus_sync2.sv | 38 +++
 rtl/ripple_count_sampler.sv | 173 +++++++++++++++++
 tb/tb_ripple_count_sampler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ripple_sampler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ripple_sampler_pkg
// Purpose  : Shared defaults and output-state encoding for the ripple-count
//            sampler.
// Contents : c_def_width, c_def_ext_width, c_def_stable_cycles,
//            out_state_t (ST_EMPTY / ST_FULL)
// Revision : 1.0 - initial release
// ============================================================================
package ripple_sampler_pkg;

  localparam int c_def_width         = 4;
  localparam int c_def_ext_width     = 8;
  localparam int c_def_stable_cycles = 2;

  // One-deep output holding register: empty or holding a record.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage
`default_nettype wire

// File: rtl/bus_sync2.sv
`default_nettype none
// ============================================================================
// Module   : bus_sync2
// Purpose  : Two-flop synchronizer for a bus driven from another timing
//            domain. Bits are synchronized independently; coherence of the
//            whole word is the job of the downstream stability filter.
// Ports    : clk  - sampling clock (rising edge)
//            rst  - asynchronous active-low reset
//            d    - asynchronous input bus
//            q    - synchronized bus (two clocks of latency)
// Revision : 1.0 - initial release
// ============================================================================
module bus_sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/ripple_count_sampler.sv
`default_nettype none
// ============================================================================
// Module   : ripple_count_sampler
// Purpose  : Samples the output of an asynchronous ripple counter, filters out
//            ripple glitches, extends the count across wrap-arounds and
//            presents each new value as a valid/ready record.
// Ports    : clk       - single clock (rising edge)
//            rst       - asynchronous active-low reset
//            cnt_in    - asynchronous ripple-counter bus [WIDTH]
//            clr       - synchronous clear (highest priority)
//            out_valid - a record is presented
//            out_ready - consumer accepts the record
//            out_count - {ext, accepted value} [EXT_WIDTH+WIDTH]
//            out_wrap  - record is the first after a wrap-around
//            drop      - one-cycle pulse: accepted value lost (register full)
// Revision : 1.0 - initial release
// ============================================================================
module ripple_count_sampler
  import ripple_sampler_pkg::*;
#(
  parameter int WIDTH         = c_def_width,
  parameter int EXT_WIDTH     = c_def_ext_width,
  parameter int STABLE_CYCLES = c_def_stable_cycles
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           cnt_in,
  input  logic                       clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXT_WIDTH+WIDTH-1:0] out_count,
  output logic                       out_wrap,
  output logic                       drop
);

  localparam logic [3:0] c_stable = 4'(STABLE_CYCLES);

  // --------------------------------------------------------------------------
  // Synchronizer
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_sync;

  bus_sync2 #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (cnt_in),
    .q   (w_sync)
  );

  // --------------------------------------------------------------------------
  // Stability filter and wrap extension
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]     r_samp;    // synchronized value seen on the previous edge
  logic [3:0]           r_streak;  // consecutive edges r_samp has been seen
  logic [WIDTH-1:0]     r_last;    // last accepted value
  logic [EXT_WIDTH-1:0] r_ext;     // wrap-extension counter

  logic [3:0]           w_streak;
  logic                 w_accept;
  logic                 w_wrap;
  logic [EXT_WIDTH-1:0] w_ext_nxt;

  always_comb begin
    // Streak length of the value currently at the synchronizer output,
    // counting this edge. Saturates so a long-held value never rolls over.
    w_streak = 4'd1;
    if (w_sync == r_samp) begin
      w_streak = (r_streak == 4'hF) ? 4'hF : r_streak + 4'd1;
    end
    w_accept  = !clr && (w_streak >= c_stable) && (w_sync != r_last);
    w_wrap    = (w_sync < r_last);
    w_ext_nxt = r_ext + EXT_WIDTH'(w_wrap);
  end

  // ext and last advance on every acceptance, including dropped ones, so
  // the extended count stays monotonic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_samp   <= '0;
      r_streak <= '0;
      r_last   <= '0;
      r_ext    <= '0;
    end else if (clr) begin
      r_samp   <= '0;
      r_streak <= '0;
      r_last   <= '0;
      r_ext    <= '0;
    end else begin
      r_samp   <= w_sync;
      r_streak <= w_streak;
      if (w_accept) begin
        r_last <= w_sync;
        r_ext  <= w_ext_nxt;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output holding register
  // --------------------------------------------------------------------------
  out_state_t r_state;
  out_state_t w_state_nxt;
  logic       w_load;
  logic       w_drop;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        // out_ready is irrelevant while nothing is presented.
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (w_accept) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end else if (w_accept) begin
          w_drop = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
    if (clr) begin
      w_state_nxt = ST_EMPTY;
      w_load      = 1'b0;
      w_drop      = 1'b0;
    end
  end

  logic [EXT_WIDTH+WIDTH-1:0] r_count;
  logic                       r_wrap;
  logic                       r_drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_drop  <= 1'b0;
    end else if (clr) begin
      r_state <= ST_EMPTY;
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop;
      if (w_load) begin
        r_count <= {w_ext_nxt, w_sync};
        r_wrap  <= w_wrap;
      end
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_count = r_count;
  assign out_wrap  = r_wrap;
  assign drop      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_ripple_count_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ripple_count_sampler
// Purpose  : Self-checking bench for ripple_count_sampler (default parameters).
//            A table of 256 counter steps checks record value, wrap flag and
//            exact latency; hand-written sequences cover async reset, drop,
//            glitch rejection and clear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ripple_count_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cnt_in;
  logic        clr;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_count;
  logic        out_wrap;
  logic        drop;

  int n_cmp  = 0;
  int n_fail = 0;

  ripple_count_sampler dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_wrap  (out_wrap),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cnt;
    logic [11:0] exp_count;
    logic        exp_wrap;
  } rec_t;

  rec_t tbl [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " valid"}, 32'(out_valid), 0);
    check({tag, " count"}, 32'(out_count), 0);
    check({tag, " wrap"},  32'(out_wrap),  0);
    check({tag, " drop"},  32'(drop),      0);
  endtask

  // Caller has just changed cnt_in (away from the edge); the record must
  // appear on exactly the 4th rising edge that follows.
  task automatic expect_rec(input string tag, input logic [11:0] exp_cnt, input logic exp_wrap);
    for (int i = 1; i < 4; i++) begin
      tick();
      check({tag, " early valid"}, 32'(out_valid), 0);
    end
    tick();
    check({tag, " valid"}, 32'(out_valid), 1);
    check({tag, " count"}, 32'(out_count), 32'(exp_cnt));
    check({tag, " wrap"},  32'(out_wrap),  32'(exp_wrap));
    check({tag, " drop"},  32'(drop),      0);
  endtask

  initial begin
    int   nrec;
    logic [11:0] seen;
    logic found;

    // Step k of a free-running 4-bit counter from 0: low nibble k%16, and the
    // extended count is simply k.
    for (int k = 1; k <= 256; k++) begin
      tbl[k-1].cnt       = 4'(k % 16);
      tbl[k-1].exp_count = 12'(k);
      tbl[k-1].exp_wrap  = ((k % 16) == 0);
    end

    rst       = 1'b0;
    cnt_in    = 4'd0;
    clr       = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b1;
    repeat (3) tick();
    check("idle at zero valid", 32'(out_valid), 0);

    // Counter walks 1..15,0 sixteen times, each value held 6 clocks.
    for (int k = 0; k < 256; k++) begin
      cnt_in = tbl[k].cnt;
      expect_rec($sformatf("step%0d", k + 1), tbl[k].exp_count, tbl[k].exp_wrap);
      tick();
      check($sformatf("step%0d consumed", k + 1), 32'(out_valid), 0);
      tick();
    end

    // Asynchronous reset while a record is held.
    out_ready = 1'b0;
    cnt_in    = 4'd9;
    expect_rec("pre-reset", 12'h109, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    check_zero("async reset");
    cnt_in = 4'd3;
    tick();
    tick();
    check_zero("held reset");
    #4;
    rst = 1'b1;
    expect_rec("post-reset", 12'h003, 1'b0);

    // Held record with consumer stalled: new value is dropped.
    cnt_in = 4'd4;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("stall hold valid", 32'(out_valid), 1);
      check("stall hold count", 32'(out_count), 32'h003);
      check("stall no drop",    32'(drop),      0);
    end
    tick();
    check("drop pulse",        32'(drop),      1);
    check("drop keeps count",  32'(out_count), 32'h003);
    check("drop keeps valid",  32'(out_valid), 1);
    tick();
    check("drop one cycle",    32'(drop),      0);
    check("drop count stable", 32'(out_count), 32'h003);
    out_ready = 1'b1;
    cnt_in    = 4'd5;
    expect_rec("after drop", 12'h005, 1'b0);

    // Glitch rejection: 7 -> 6 -> 4 -> 8 with intermediates one clock each.
    cnt_in = 4'd7;
    expect_rec("glitch base", 12'h007, 1'b0);
    cnt_in = 4'd6;
    nrec = 0;
    seen = '0;
    tick();
    if (out_valid) begin nrec++; seen = out_count; end
    cnt_in = 4'd4;
    tick();
    if (out_valid) begin nrec++; seen = out_count; end
    cnt_in = 4'd8;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) begin
        nrec++;
        seen = out_count;
        check("glitch wrap", 32'(out_wrap), 0);
      end
    end
    check("glitch record count", 32'(nrec), 1);
    check("glitch record value", 32'(seen), 32'h008);

    // Clear coincident with an acceptance (consumer ready).
    cnt_in = 4'd10;
    tick();
    tick();
    tick();
    check("pre-clr valid", 32'(out_valid), 0);
    clr = 1'b1;
    tick();
    check_zero("clr on accept");
    clr   = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      if (out_valid) found = 1'b1;
    end
    check("post-clr record seen", 32'(found),     1);
    check("post-clr count",       32'(out_count), 32'h00A);
    check("post-clr wrap",        32'(out_wrap),  0);

    // Counter wraps to 0, then clear: a stable 0 must not be recorded.
    cnt_in = 4'd0;
    expect_rec("wrap to 0", 12'h010, 1'b1);
    tick();
    clr = 1'b1;
    tick();
    check_zero("idle clr");
    clr  = 1'b0;
    nrec = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) nrec++;
    end
    check("zero after clr ignored", 32'(nrec), 0);
    cnt_in = 4'd3;
    expect_rec("clr then 3", 12'h003, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard stop in case the main sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
